// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//   Game-flow controller for the Breakout datapath. Walks the game through
//   IDLE, SERVE, PLAY, MISS, CLEAR, OVER (and optionally PAUSED), keeps the
//   lives and level counters, gates all motion through `run`, and issues
//   one-cycle reset pulses to the ball and the block bank.
//
//   Optional feature macro: GAME_SEQUENCER_PAUSE_EN
//     defined   : a pause rising edge toggles PLAY <-> PAUSED
//     undefined : the pause input is accepted but has no effect
//
// Ports
//   clock         in   pixel clock (VGA_CLK)
//   reset         in   asynchronous reset, active low
//   frame_tick    in   one-cycle pulse per frame
//   start         in   level; rising edge starts a game from IDLE
//   pause         in   level; rising edge toggles pause (feature macro only)
//   hit_block     in   ball hit a block this cycle
//   endgame_ball  in   ball reached the lava
//   endgame_block in   a block reached the bottom of the screen
//   exist         in   per-block alive flags
//   state         out  IDLE=0 SERVE=1 PLAY=2 MISS=3 CLEAR=4 OVER=5 PAUSED=6
//   run           out  high only in PLAY
//   ball_rst      out  one-cycle pulse, ball back to serve position
//   blocks_rst    out  one-cycle pulse, all blocks re-created
//   lives         out  remaining lives
//   level         out  current level / speed select
//   score_pulse   out  registered (run & hit_block)
// -----------------------------------------------------------------------------
module game_sequencer #(
    parameter int LIVES        = 3,
    parameter int NUM_BLOCKS   = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 90,
    parameter int OVER_FRAMES  = 180,
    parameter int MAX_LEVEL    = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  hit_block,
    input  logic                  endgame_ball,
    input  logic                  endgame_block,
    input  logic [NUM_BLOCKS-1:0] exist,
    output logic [2:0]            state,
    output logic                  run,
    output logic                  ball_rst,
    output logic                  blocks_rst,
    output logic [2:0]            lives,
    output logic [2:0]            level,
    output logic                  score_pulse
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SERVE  = 3'd1;
    localparam logic [2:0] PLAY   = 3'd2;
    localparam logic [2:0] MISS   = 3'd3;
    localparam logic [2:0] CLEAR  = 3'd4;
    localparam logic [2:0] OVER   = 3'd5;
    localparam logic [2:0] PAUSED = 3'd6;

    localparam int MAX_A      = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int MAX_FRAMES = (MAX_A > OVER_FRAMES) ? MAX_A : OVER_FRAMES;
    localparam int TW         = (MAX_FRAMES < 1) ? 1 : $clog2(MAX_FRAMES + 1);

    localparam logic [TW-1:0] T_SERVE = TW'(SERVE_FRAMES);
    localparam logic [TW-1:0] T_MISS  = TW'(MISS_FRAMES);
    localparam logic [TW-1:0] T_OVER  = TW'(OVER_FRAMES);
    localparam logic [2:0]    L_LOAD  = 3'(LIVES);
    localparam logic [2:0]    L_MAX   = 3'(MAX_LEVEL);

    logic [2:0]    state_r, state_n_s;
    logic [TW-1:0] timer_r, timer_n_s, timer_dec_s;
    logic [2:0]    lives_r, lives_n_s;
    logic [2:0]    level_r, level_n_s;
    logic          run_r, ball_rst_r, blocks_rst_r, score_pulse_r;
    logic          ball_rst_n_s, blocks_rst_n_s;
    logic          start_q_r, start_rise_s;
    logic          timer_zero_s, no_blocks_s;

`ifdef GAME_SEQUENCER_PAUSE_EN
    logic          pause_q_r, pause_rise_s;
    assign pause_rise_s = pause & ~pause_q_r;
`else
    logic          unused_pause_s;
    assign unused_pause_s = pause;
`endif

    assign start_rise_s = start & ~start_q_r;
    assign timer_zero_s = (timer_r == {TW{1'b0}});
    assign no_blocks_s  = (exist == {NUM_BLOCKS{1'b0}});
    // The timer only counts frames; it holds between ticks.
    assign timer_dec_s  = frame_tick ? (timer_r - TW'(1)) : timer_r;

    // Next-state, counter and pulse decode for the game flow.
    always_comb begin
        state_n_s      = state_r;
        timer_n_s      = timer_r;
        lives_n_s      = lives_r;
        level_n_s      = level_r;
        ball_rst_n_s   = 1'b0;
        blocks_rst_n_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_rise_s) begin
                    state_n_s      = SERVE;
                    timer_n_s      = T_SERVE;
                    lives_n_s      = L_LOAD;
                    level_n_s      = 3'd0;
                    ball_rst_n_s   = 1'b1;
                    blocks_rst_n_s = 1'b1;
                end else begin
                    state_n_s = IDLE;
                end
            end
            SERVE: begin
                if (timer_zero_s) begin
                    state_n_s = PLAY;
                end else begin
                    timer_n_s = timer_dec_s;
                end
            end
            PLAY: begin
                // A block at the bottom ends the game outright; a lost ball
                // outranks a cleared field.
                if (endgame_block) begin
                    state_n_s = OVER;
                    timer_n_s = T_OVER;
                    lives_n_s = 3'd0;
                end else if (endgame_ball) begin
                    state_n_s = MISS;
                    timer_n_s = T_MISS;
                    if (lives_r != 3'd0) begin
                        lives_n_s = lives_r - 3'd1;
                    end else begin
                        lives_n_s = 3'd0;
                    end
                end else if (no_blocks_s) begin
                    state_n_s = CLEAR;
                    timer_n_s = T_SERVE;
`ifdef GAME_SEQUENCER_PAUSE_EN
                end else if (pause_rise_s) begin
                    state_n_s = PAUSED;
`endif
                end else begin
                    state_n_s = PLAY;
                end
            end
            MISS: begin
                if (!timer_zero_s) begin
                    timer_n_s = timer_dec_s;
                end else if (lives_r == 3'd0) begin
                    state_n_s = OVER;
                    timer_n_s = T_OVER;
                end else begin
                    state_n_s    = SERVE;
                    timer_n_s    = T_SERVE;
                    ball_rst_n_s = 1'b1;
                end
            end
            CLEAR: begin
                if (timer_zero_s) begin
                    state_n_s      = SERVE;
                    timer_n_s      = T_SERVE;
                    ball_rst_n_s   = 1'b1;
                    blocks_rst_n_s = 1'b1;
                    if (level_r >= L_MAX) begin
                        level_n_s = L_MAX;
                    end else begin
                        level_n_s = level_r + 3'd1;
                    end
                end else begin
                    timer_n_s = timer_dec_s;
                end
            end
            OVER: begin
                if (timer_zero_s) begin
                    state_n_s = IDLE;
                end else begin
                    timer_n_s = timer_dec_s;
                end
            end
            PAUSED: begin
`ifdef GAME_SEQUENCER_PAUSE_EN
                // Endgame inputs are ignored here; only pause resumes play.
                if (pause_rise_s) begin
                    state_n_s = PLAY;
                end else begin
                    state_n_s = PAUSED;
                end
`else
                state_n_s = IDLE;
`endif
            end
            default: begin
                state_n_s = IDLE;
                timer_n_s = {TW{1'b0}};
            end
        endcase
    end

    // Registered state, counters and outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            timer_r       <= {TW{1'b0}};
            lives_r       <= L_LOAD;
            level_r       <= 3'd0;
            run_r         <= 1'b0;
            ball_rst_r    <= 1'b0;
            blocks_rst_r  <= 1'b0;
            score_pulse_r <= 1'b0;
            start_q_r     <= 1'b0;
        end else begin
            state_r       <= state_n_s;
            timer_r       <= timer_n_s;
            lives_r       <= lives_n_s;
            level_r       <= level_n_s;
            run_r         <= (state_n_s == PLAY);
            ball_rst_r    <= ball_rst_n_s;
            blocks_rst_r  <= blocks_rst_n_s;
            // run_r is high exactly in PLAY, so hits elsewhere never score.
            score_pulse_r <= run_r & hit_block;
            start_q_r     <= start;
        end
    end

`ifdef GAME_SEQUENCER_PAUSE_EN
    // Previous pause level for rising-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pause_q_r <= 1'b0;
        end else begin
            pause_q_r <= pause;
        end
    end
`endif

    assign state       = state_r;
    assign run         = run_r;
    assign ball_rst    = ball_rst_r;
    assign blocks_rst  = blocks_rst_r;
    assign lives       = lives_r;
    assign level       = level_r;
    assign score_pulse = score_pulse_r;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//   Directed game scenarios with randomized background traffic (frame ticks,
//   hits, spurious endgame/start inputs outside the states that honour them),
//   compared every cycle against a phase-level model of the game rules.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       hit_block = 1'b0;
    logic       endgame_ball = 1'b0;
    logic       endgame_block = 1'b0;
    logic [4:0] exist = 5'd1;
    logic [2:0] state;
    logic       run;
    logic       ball_rst;
    logic       blocks_rst;
    logic [2:0] lives;
    logic [2:0] level;
    logic       score_pulse;

    game_sequencer dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
        .pause(pause), .hit_block(hit_block), .endgame_ball(endgame_ball),
        .endgame_block(endgame_block), .exist(exist), .state(state), .run(run),
        .ball_rst(ball_rst), .blocks_rst(blocks_rst), .lives(lives),
        .level(level), .score_pulse(score_pulse)
    );

    always #5 clock = ~clock;

`ifdef GAME_SEQUENCER_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_MISS = 3,
                   P_CLEAR = 4, P_OVER = 5, P_PAUSED = 6;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase, frames seen in the current phase, counters.
    int m_phase, m_frames, m_lives, m_level;
    int m_ball, m_blocks, m_score;
    int m_start_prev, m_pause_prev;

    function automatic int phase_length(input int p);
        case (p)
            P_SERVE, P_CLEAR: return 60;
            P_MISS:           return 90;
            P_OVER:           return 180;
            default:          return 0;
        endcase
    endfunction

    task automatic enter(input int p);
        m_phase  = p;
        m_frames = 0;
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_frames = 0; m_lives = 3; m_level = 0;
        m_ball = 0; m_blocks = 0; m_score = 0;
        m_start_prev = 0; m_pause_prev = 0;
    endtask

    // Apply the game rules for one clock edge using the inputs present there.
    task automatic model_edge();
        bit start_edge, pause_edge;
        start_edge   = start && !m_start_prev;
        pause_edge   = pause && !m_pause_prev;
        m_start_prev = start;
        m_pause_prev = pause;
        m_score  = (m_phase == P_PLAY && hit_block) ? 1 : 0;
        m_ball   = 0;
        m_blocks = 0;
        if (m_phase == P_IDLE) begin
            if (start_edge) begin
                enter(P_SERVE);
                m_lives = 3; m_level = 0; m_ball = 1; m_blocks = 1;
            end
        end else if (m_phase == P_PLAY) begin
            if (endgame_block) begin
                m_lives = 0; enter(P_OVER);
            end else if (endgame_ball) begin
                m_lives = (m_lives > 0) ? m_lives - 1 : 0; enter(P_MISS);
            end else if (exist == 5'd0) begin
                enter(P_CLEAR);
            end else if (PAUSE_EN && pause_edge) begin
                m_phase = P_PAUSED;
            end
        end else if (m_phase == P_PAUSED) begin
            if (pause_edge) m_phase = P_PLAY;
        end else if (m_frames == phase_length(m_phase)) begin
            case (m_phase)
                P_SERVE: enter(P_PLAY);
                P_MISS: begin
                    if (m_lives == 0) enter(P_OVER);
                    else begin enter(P_SERVE); m_ball = 1; end
                end
                P_CLEAR: begin
                    m_level = (m_level + 1 > 7) ? 7 : m_level + 1;
                    m_ball = 1; m_blocks = 1; enter(P_SERVE);
                end
                default: enter(P_IDLE);
            endcase
        end else if (frame_tick) begin
            m_frames++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("state", {29'd0, state}, m_phase);
        chk("run", {31'd0, run}, (m_phase == P_PLAY) ? 1 : 0);
        chk("ball_rst", {31'd0, ball_rst}, m_ball);
        chk("blocks_rst", {31'd0, blocks_rst}, m_blocks);
        chk("lives", {29'd0, lives}, m_lives);
        chk("level", {29'd0, level}, m_level);
        chk("score_pulse", {31'd0, score_pulse}, m_score);
    endtask

    // Background traffic: inputs that the current phase must ignore are toggled freely.
    task automatic noise();
        frame_tick = 1'($urandom_range(0, 1));
        hit_block  = 1'($urandom_range(0, 1));
        if (m_phase == P_PLAY) begin
            endgame_ball = 1'b0; endgame_block = 1'b0;
            exist = 5'($urandom_range(1, 31));
        end else begin
            endgame_ball  = ($urandom_range(0, 7) == 0);
            endgame_block = ($urandom_range(0, 7) == 0);
            exist = 5'($urandom_range(0, 31));
        end
        start = (m_phase == P_IDLE) ? 1'b0 : 1'($urandom_range(0, 1));
        pause = (m_phase == P_PLAY || m_phase == P_PAUSED) ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_until(input int target, input string tag);
        int k;
        k = 0;
        while (m_phase != target && k < 1000) begin
            noise();
            cycle();
            k++;
        end
        chk(tag, m_phase, target);
    endtask

    task automatic new_game();
        run_until(P_IDLE, "reach_idle");
        noise(); cycle();
        noise(); start = 1'b1; cycle();
        run_until(P_PLAY, "reach_play");
    endtask

    initial begin
        // Reset values
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset = 1'b1;

        // Start, serve, some play with hits
        new_game();
        repeat (6) begin noise(); cycle(); end

        // Three misses: lives 2,1,0 then OVER and back to IDLE
        for (int i = 0; i < 3; i++) begin
            noise(); endgame_ball = 1'b1; cycle();
            if (i < 2) run_until(P_PLAY, "replay_after_miss");
        end
        run_until(P_OVER, "reach_over");
        chk("lives_empty", {29'd0, lives}, 0);

        // Eight clears from level 0: level saturates at 7
        new_game();
        for (int i = 0; i < 8; i++) begin
            noise(); exist = 5'b00001; cycle();
            noise(); exist = 5'b00000; cycle();
            run_until(P_PLAY, "replay_after_clear");
        end
        chk("level_saturated", {29'd0, level}, 7);

        // Lost ball and empty field together: MISS wins
        noise(); endgame_ball = 1'b1; exist = 5'd0; cycle();
        chk("miss_wins", {29'd0, state}, P_MISS);
        run_until(P_PLAY, "replay_after_miss2");

        // Block at bottom: straight to OVER with no lives
        noise(); endgame_block = 1'b1; cycle();
        chk("block_over", {29'd0, state}, P_OVER);

        // Pause sequence (only effective with the pause feature)
        new_game();
        noise(); pause = 1'b1; cycle();
        for (int i = 0; i < 3; i++) begin
            noise(); pause = 1'b1; endgame_ball = 1'b1; endgame_block = 1'b0; exist = 5'd0; cycle();
        end
        noise(); pause = 1'b0; cycle();
        noise(); pause = 1'b1; cycle();
        run_until(P_PLAY, "play_after_pause");

        // Asynchronous reset mid-PLAY
        repeat (3) begin noise(); cycle(); end
        #2;
        reset = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b1;
        repeat (4) begin noise(); cycle(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
